// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the hazard/stall logic.
package pipe_pkg;

    // Tuse/Tnew distance in cycles.
    typedef logic [1:0] t_cnt2;

    // Tuse value meaning "operand is never read".
    localparam t_cnt2 TUSE_NONE = 2'd3;

    // Qualifier for E_start.
    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    // Instruction word the D/E register holds while it carries a bubble.
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;

    // True when a later-stage producer of reg 'dst' cannot supply 'src' in time.
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input t_cnt2      tuse,
        input logic [4:0] dst,
        input logic       we,
        input t_cnt2      tnew
    );
        return we && (dst == src) && (src != 5'd0) &&
               (tuse != TUSE_NONE) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_counter.sv
// Multiply/divide busy counter: loads the operation latency on a start and
// counts down to zero; busy while non-zero.
module md_busy_counter
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic md_div_i,
    output logic busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: a start only loads when idle; otherwise count down.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i && (cnt_q == '0)) begin
            cnt_d = (md_div_i == MD_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// Hazard controller: decides whether the D instruction may advance, freezes
// PC and F/D and bubbles D/E when it may not, and counts stalled cycles.
module stall_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  t_cnt2       D_Tuse_rs,
    input  t_cnt2       D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_RegAddr,
    input  logic [4:0]  M_RegAddr,
    input  logic        E_RegWrite,
    input  logic        M_RegWrite,
    input  t_cnt2       E_Tnew,
    input  t_cnt2       M_Tnew,
    input  logic        E_start,
    input  logic        E_md_div,
    output logic        F_en,
    output logic        D_en,
    output logic        E_clr,
    output logic        busy,
    output logic [31:0] stall_cnt
);

    logic        reg_hz;
    logic        md_hz;
    logic        stall;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy (
        .clk      (clk),
        .reset    (reset),
        .start_i  (E_start),
        .md_div_i (E_md_div),
        .busy_o   (busy)
    );

    // Stall decision: register hazards on rs/rt against E and M, plus HI/LO access while the MDU is occupied.
    always_comb begin
        reg_hz = reg_hazard(D_rs, D_Tuse_rs, E_RegAddr, E_RegWrite, E_Tnew) ||
                 reg_hazard(D_rs, D_Tuse_rs, M_RegAddr, M_RegWrite, M_Tnew) ||
                 reg_hazard(D_rt, D_Tuse_rt, E_RegAddr, E_RegWrite, E_Tnew) ||
                 reg_hazard(D_rt, D_Tuse_rt, M_RegAddr, M_RegWrite, M_Tnew);
        md_hz  = D_is_md && (busy || E_start);
        stall  = reg_hz || md_hz;
    end

    assign F_en  = !stall;
    assign D_en  = !stall;
    assign E_clr = stall;

    // Stall statistic: free-running, wraps naturally at 2^32.
    always_comb begin
        stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    // Stall statistic register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: a behavioural model predicts outputs each
// cycle, expectations are queued at drive time and compared when sampled.
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_RegAddr, M_RegAddr;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic        D_is_md, E_RegWrite, M_RegWrite, E_start, E_md_div;
    logic        F_en, D_en, E_clr, busy;
    logic [31:0] stall_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Model state
    int unsigned m_cnt  = 0;
    logic [31:0] m_scnt = '0;

    typedef struct {
        string       tag;
        logic        f_en;
        logic        d_en;
        logic        e_clr;
        logic        busy;
        logic [31:0] scnt;
    } exp_t;

    exp_t sb[$];

    stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_Tuse_rs  (D_Tuse_rs),
        .D_Tuse_rt  (D_Tuse_rt),
        .D_is_md    (D_is_md),
        .E_RegAddr  (E_RegAddr),
        .M_RegAddr  (M_RegAddr),
        .E_RegWrite (E_RegWrite),
        .M_RegWrite (M_RegWrite),
        .E_Tnew     (E_Tnew),
        .M_Tnew     (M_Tnew),
        .E_start    (E_start),
        .E_md_div   (E_md_div),
        .F_en       (F_en),
        .D_en       (D_en),
        .E_clr      (E_clr),
        .busy       (busy),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // The pipeline must never issue a new mult/div while the MDU is busy.
    always @(posedge clk) begin
        if (!reset && E_start && busy) $error("E_start issued while busy");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit hz(input logic [4:0] src, input logic [1:0] tuse,
                              input logic [4:0] dst, input logic we, input logic [1:0] tnew);
        if (!we || src == 5'd0 || dst != src || tuse == 2'd3) return 1'b0;
        return tuse < tnew;
    endfunction

    task automatic zero_inputs();
        reset = 0; D_rs = 0; D_rt = 0; D_Tuse_rs = 3; D_Tuse_rt = 3; D_is_md = 0;
        E_RegAddr = 0; M_RegAddr = 0; E_RegWrite = 0; M_RegWrite = 0;
        E_Tnew = 0; M_Tnew = 0; E_start = 0; E_md_div = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick(input string tag);
        exp_t e;
        exp_t o;
        bit   st;
        st = hz(D_rs, D_Tuse_rs, E_RegAddr, E_RegWrite, E_Tnew) ||
             hz(D_rs, D_Tuse_rs, M_RegAddr, M_RegWrite, M_Tnew) ||
             hz(D_rt, D_Tuse_rt, E_RegAddr, E_RegWrite, E_Tnew) ||
             hz(D_rt, D_Tuse_rt, M_RegAddr, M_RegWrite, M_Tnew) ||
             (D_is_md && (m_cnt != 0 || E_start));
        e.tag = tag; e.f_en = !st; e.d_en = !st; e.e_clr = st;
        e.busy = (m_cnt != 0); e.scnt = m_scnt;
        sb.push_back(e);
        #2;
        o = sb.pop_front();
        chk({o.tag, ".F_en"},      32'(F_en),  32'(o.f_en));
        chk({o.tag, ".D_en"},      32'(D_en),  32'(o.d_en));
        chk({o.tag, ".E_clr"},     32'(E_clr), 32'(o.e_clr));
        chk({o.tag, ".busy"},      32'(busy),  32'(o.busy));
        chk({o.tag, ".stall_cnt"}, stall_cnt,  o.scnt);
        @(posedge clk);
        if (reset) begin
            m_cnt  = 0;
            m_scnt = '0;
        end else begin
            if (st) m_scnt = m_scnt + 32'd1;
            if (E_start && m_cnt == 0) m_cnt = E_md_div ? 10 : 5;
            else if (m_cnt != 0)       m_cnt = m_cnt - 1;
        end
        @(negedge clk);
    endtask

    initial begin
        zero_inputs();
        reset = 1;
        #1;
        tick("rst0");
        tick("rst1");
        reset = 0;
        tick("idle");

        // Load-use on rs: producer in E, then in M, then ready.
        E_RegAddr = 8; E_RegWrite = 1; E_Tnew = 2; D_rs = 8; D_Tuse_rs = 1;
        tick("lu_E");
        E_RegAddr = 0; E_RegWrite = 0; E_Tnew = 0;
        M_RegAddr = 8; M_RegWrite = 1; M_Tnew = 1;
        tick("lu_M");
        M_Tnew = 0;
        tick("lu_ok");
        zero_inputs();

        // Register $0 never hazards; unused rt never hazards.
        D_rs = 0; D_Tuse_rs = 0; E_RegAddr = 0; E_RegWrite = 1; E_Tnew = 2;
        tick("r0");
        D_rs = 0; D_rt = 9; D_Tuse_rt = 3; E_RegAddr = 9;
        tick("rt_unused");
        D_Tuse_rt = 0;
        tick("rt_hz");
        zero_inputs();

        // Multiply: mflo waits through the busy window.
        E_start = 1; E_md_div = 0;
        tick("mul_start");
        E_start = 0; D_is_md = 1;
        for (int unsigned i = 0; i < 5; i++) tick($sformatf("mul_busy%0d", i));
        tick("mul_done");
        zero_inputs();

        // Simultaneous start and MD instruction in D; non-MD while busy.
        E_start = 1; E_md_div = 0; D_is_md = 1;
        tick("simul");
        E_start = 0; D_is_md = 0;
        for (int unsigned i = 0; i < 5; i++) tick($sformatf("nonmd%0d", i));

        // Divide, reset on the 4th busy cycle.
        E_start = 1; E_md_div = 1;
        tick("div_start");
        E_start = 0;
        for (int unsigned i = 0; i < 3; i++) tick($sformatf("div_busy%0d", i));
        reset = 1; D_is_md = 1;
        tick("div_rst");
        zero_inputs();
        tick("post_rst");

        // Pseudo-random mix with collisions on a small register set.
        for (int unsigned i = 0; i < 60; i++) begin
            D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
            D_Tuse_rs = 2'($urandom_range(0, 3)); D_Tuse_rt = 2'($urandom_range(0, 3));
            E_RegAddr = 5'($urandom_range(0, 3)); M_RegAddr = 5'($urandom_range(0, 3));
            E_RegWrite = 1'($urandom_range(0, 1)); M_RegWrite = 1'($urandom_range(0, 1));
            E_Tnew = 2'($urandom_range(0, 3)); M_Tnew = 2'($urandom_range(0, 3));
            D_is_md = 1'($urandom_range(0, 1));
            E_start = (m_cnt == 0) && ($urandom_range(0, 3) == 0);
            E_md_div = 1'($urandom_range(0, 1));
            tick($sformatf("rnd%0d", i));
        end
        zero_inputs();
        for (int unsigned i = 0; i < 12; i++) tick($sformatf("drain%0d", i));

        // Statistic wrap from all-ones to zero.
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        m_scnt = 32'hFFFF_FFFF;
        E_RegAddr = 5; E_RegWrite = 1; E_Tnew = 2; D_rs = 5; D_Tuse_rs = 0;
        tick("wrap_pre");
        zero_inputs();
        tick("wrap_post");
        chk("wrap_zero", stall_cnt, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
